// File: rtl/md_hazard_ctrl_if.sv
// Bundle of the signals exchanged between the pipeline, the multiply/divide
// unit and the HI/LO hazard controller.
//   instr_D, instr_E : instructions in the D and E stages
//   IRQ_E            : exception/interrupt taken at E (blocks issue)
//   md_busy          : busy flag reported by the multiply/divide unit
//   stall            : freeze PC/D and bubble E
//   md_active        : an operation is in START or BUSY
//   cycles_left      : remaining BUSY cycles (0 outside BUSY)
//   is_div           : in-flight operation is div/divu
//   sync_err         : sticky protocol/consistency error
// master = pipeline side (drives instructions and md_busy),
// slave  = hazard controller.
interface md_hazard_ctrl_if;
    logic [31:0] instr_D;
    logic [31:0] instr_E;
    logic        IRQ_E;
    logic        md_busy;
    logic        stall;
    logic        md_active;
    logic [3:0]  cycles_left;
    logic        is_div;
    logic        sync_err;

    modport master (
        output instr_D, instr_E, IRQ_E, md_busy,
        input  stall, md_active, cycles_left, is_div, sync_err
    );

    modport slave (
        input  instr_D, instr_E, IRQ_E, md_busy,
        output stall, md_active, cycles_left, is_div, sync_err
    );
endinterface

// File: rtl/md_hazard_ctrl.sv
// HI/LO hazard controller for the multiply/divide unit.
// Tracks each mult/multu/div/divu from issue at E through a one-cycle START
// phase and a BUSY phase of MULT_CYCLES or DIV_CYCLES, stalls D for any
// HI/LO-touching instruction while an operation is in flight (or issuing),
// and cross-checks the shadow counter against the unit's md_busy flag.
// Ports: clk, reset (async, active-low), bus (md_hazard_ctrl_if.slave).
module md_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    md_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    // mult/multu/div/divu: SPECIAL opcode, funct 0110xx
    function automatic logic is_md_op(input logic [31:0] instr);
        return (instr[31:26] == 6'b000000) && (instr[5:2] == 4'b0110);
    endfunction

    // Any HI/LO access: MD op or mfhi/mthi/mflo/mtlo (funct 0100xx)
    function automatic logic uses_hilo(input logic [31:0] instr);
        return is_md_op(instr) ||
               ((instr[31:26] == 6'b000000) && (instr[5:2] == 4'b0100));
    endfunction

    logic [1:0] state_r;
    logic [1:0] state_nx_s;
    logic [3:0] cycles_left_r;
    logic [3:0] cycles_nx_s;
    logic       is_div_r;
    logic       is_div_nx_s;
    logic       md_active_r;
    logic       sync_err_r;
    logic       sync_err_nx_s;
    logic       prev_busy_r;
    logic       md_op_e_s;
    logic       issue_s;

    assign md_op_e_s = is_md_op(bus.instr_E);
    assign issue_s   = md_op_e_s && !bus.IRQ_E;

    // Next-state, counter and op-type selection
    always_comb begin
        state_nx_s  = state_r;
        cycles_nx_s = cycles_left_r;
        is_div_nx_s = is_div_r;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    state_nx_s  = START;
                    is_div_nx_s = bus.instr_E[1];
                    cycles_nx_s = 4'd0;
                end else begin
                    cycles_nx_s = 4'd0;
                end
            end
            START: begin
                state_nx_s  = BUSY;
                cycles_nx_s = is_div_r ? DIV_LAT : MULT_LAT;
            end
            BUSY: begin
                // <= 1 also drains a corrupted zero count safely
                if (cycles_left_r <= 4'd1) begin
                    state_nx_s  = IDLE;
                    cycles_nx_s = 4'd0;
                end else begin
                    cycles_nx_s = cycles_left_r - 4'd1;
                end
            end
            default: begin
                state_nx_s  = IDLE;
                cycles_nx_s = 4'd0;
                is_div_nx_s = 1'b0;
            end
        endcase
    end

    // Sticky error: counter/busy disagreement or an MD op issued while in flight.
    // The first IDLE cycle after BUSY tolerates a late md_busy release.
    always_comb begin
        sync_err_nx_s = sync_err_r;
        if ((state_r == BUSY) && !bus.md_busy) begin
            sync_err_nx_s = 1'b1;
        end else if ((state_r == IDLE) && bus.md_busy && !prev_busy_r) begin
            sync_err_nx_s = 1'b1;
        end else if ((state_r != IDLE) && issue_s) begin
            sync_err_nx_s = 1'b1;
        end else begin
            sync_err_nx_s = sync_err_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            cycles_left_r <= 4'd0;
            is_div_r      <= 1'b0;
            md_active_r   <= 1'b0;
            sync_err_r    <= 1'b0;
            prev_busy_r   <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            cycles_left_r <= cycles_nx_s;
            is_div_r      <= is_div_nx_s;
            md_active_r   <= (state_nx_s != IDLE);
            sync_err_r    <= sync_err_nx_s;
            prev_busy_r   <= (state_r == BUSY);
        end
    end

    // Stall must react in the issue cycle itself, so it stays combinational;
    // gating with reset drops it the moment reset is asserted.
    assign bus.stall       = reset && uses_hilo(bus.instr_D) &&
                             ((state_r != IDLE) || issue_s);
    assign bus.md_active   = md_active_r;
    assign bus.cycles_left = cycles_left_r;
    assign bus.is_div      = is_div_r;
    assign bus.sync_err    = sync_err_r;
endmodule

// File: tb/tb_md_hazard_ctrl.sv
module tb_md_hazard_ctrl;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MULT  = 32'h0000_0018;
    localparam logic [31:0] MULTU = 32'h0000_0019;
    localparam logic [31:0] DIV   = 32'h0000_001A;
    localparam logic [31:0] DIVU  = 32'h0000_001B;
    localparam logic [31:0] MFHI  = 32'h0000_0010;
    localparam logic [31:0] MTHI  = 32'h0000_0011;
    localparam logic [31:0] MFLO  = 32'h0000_0012;
    localparam logic [31:0] MTLO  = 32'h0000_0013;
    localparam logic [31:0] ADDU  = 32'h0000_0021;
    localparam logic [31:0] ADDI18 = 32'h2000_0018;  // non-SPECIAL, funct bits look like mult
    localparam logic [31:0] ADDI1A = 32'h2000_001A;  // non-SPECIAL, funct bits look like div
    localparam logic [31:0] F14   = 32'h0000_0014;   // SPECIAL funct 010100, not HI/LO

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    md_hazard_ctrl_if bus();

    md_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] e;
        logic        irq;
        logic        exp_idle;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply every stall vector within one low clock phase, then restore inputs
    task automatic run_table(input logic busy_phase, input logic [31:0] d_restore);
        for (int i = 0; i < 12; i++) begin
            bus.instr_D = vecs[i].d;
            bus.instr_E = vecs[i].e;
            bus.IRQ_E   = vecs[i].irq;
            #1;
            chk($sformatf("stall_vec%0d_%s", i, busy_phase ? "busy" : "idle"),
                {31'd0, bus.stall},
                {31'd0, busy_phase ? vecs[i].exp_busy : vecs[i].exp_idle});
        end
        bus.instr_D = d_restore;
        bus.instr_E = NOP;
        bus.IRQ_E   = 1'b0;
    endtask

    // Issue op at E; returns at the negedge of the START cycle with md_busy=1
    task automatic issue(input logic [31:0] op);
        @(negedge clk);
        bus.instr_E = op;
        @(negedge clk);
        bus.instr_E = NOP;
        bus.md_busy = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.md_busy = 1'b0;
        #2;
        chk("reset_clears_err", {31'd0, bus.sync_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_cl [7];
        logic       exp_act [7];
        checks = 0;
        errors = 0;

        vecs[0]  = '{MFHI, NOP,    1'b0, 1'b0, 1'b1};
        vecs[1]  = '{MFHI, MULT,   1'b0, 1'b1, 1'b1};
        vecs[2]  = '{MFHI, MULTU,  1'b1, 1'b0, 1'b1};
        vecs[3]  = '{ADDU, MULT,   1'b0, 1'b0, 1'b0};
        vecs[4]  = '{MULT, MULT,   1'b0, 1'b1, 1'b1};
        vecs[5]  = '{MTLO, DIV,    1'b0, 1'b1, 1'b1};
        vecs[6]  = '{MTHI, NOP,    1'b0, 1'b0, 1'b1};
        vecs[7]  = '{ADDI18, MULT, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{MFLO, ADDI1A, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{ADDU, NOP,    1'b0, 1'b0, 1'b0};
        vecs[10] = '{DIVU, NOP,    1'b1, 1'b0, 1'b1};
        vecs[11] = '{F14,  DIVU,   1'b0, 1'b0, 1'b0};

        // Reset state, with a would-stall pattern present
        reset = 1'b0;
        bus.instr_D = MFLO;
        bus.instr_E = MULT;
        bus.IRQ_E   = 1'b0;
        bus.md_busy = 1'b0;
        #3;
        chk("rst_stall",     {31'd0, bus.stall},     32'd0);
        chk("rst_md_active", {31'd0, bus.md_active}, 32'd0);
        chk("rst_cycles",    {28'd0, bus.cycles_left}, 32'd0);
        chk("rst_is_div",    {31'd0, bus.is_div},    32'd0);
        chk("rst_sync_err",  {31'd0, bus.sync_err},  32'd0);
        bus.instr_D = NOP;
        bus.instr_E = NOP;
        @(negedge clk);
        reset = 1'b1;

        // Stall decode in IDLE
        @(negedge clk);
        run_table(1'b0, NOP);

        // Mult issue: START then 5,4,3,2,1 then IDLE; md_busy held one extra cycle
        exp_cl  = '{4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        exp_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        issue(MULT);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("mult_active_%0d", k), {31'd0, bus.md_active}, {31'd0, exp_act[k]});
            chk($sformatf("mult_cycles_%0d", k), {28'd0, bus.cycles_left}, {28'd0, exp_cl[k]});
        end
        chk("mult_is_div", {31'd0, bus.is_div}, 32'd0);
        @(negedge clk);
        chk("mult_slack_no_err", {31'd0, bus.sync_err}, 32'd0);
        bus.md_busy = 1'b0;

        // Divide with dependent mflo in D
        @(negedge clk);
        bus.instr_D = MFLO;
        bus.instr_E = DIV;
        #1;
        chk("div_stall_issue", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        bus.instr_E = NOP;
        bus.md_busy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("div_stall_%0d", k), {31'd0, bus.stall}, {31'd0, (k < 11)});
            chk($sformatf("div_cycles_%0d", k), {28'd0, bus.cycles_left},
                (k == 0 || k == 11) ? 32'd0 : 32'(11 - k));
            if (k < 11) chk($sformatf("div_is_div_%0d", k), {31'd0, bus.is_div}, 32'd1);
            if (k == 3) run_table(1'b1, MFLO);
        end
        chk("div_active_done", {31'd0, bus.md_active}, 32'd0);
        chk("div_no_err", {31'd0, bus.sync_err}, 32'd0);
        bus.md_busy = 1'b0;
        bus.instr_D = NOP;

        // Interrupt suppression
        @(negedge clk);
        bus.instr_D = MFHI;
        bus.instr_E = MULTU;
        bus.IRQ_E   = 1'b1;
        #1;
        chk("irq_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        chk("irq_active", {31'd0, bus.md_active}, 32'd0);
        chk("irq_err", {31'd0, bus.sync_err}, 32'd0);
        bus.instr_E = NOP;
        bus.IRQ_E   = 1'b0;
        bus.instr_D = NOP;

        // Protocol violation: divu forced into E while BUSY
        issue(MULT);
        @(negedge clk);
        @(negedge clk);
        chk("pv1_cycles_pre", {28'd0, bus.cycles_left}, 32'd4);
        bus.instr_E = DIVU;
        @(negedge clk);
        bus.instr_E = NOP;
        chk("pv1_cycles", {28'd0, bus.cycles_left}, 32'd3);
        chk("pv1_is_div", {31'd0, bus.is_div}, 32'd0);
        chk("pv1_err", {31'd0, bus.sync_err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("pv1_done", {31'd0, bus.md_active}, 32'd0);
        chk("pv1_err_sticky", {31'd0, bus.sync_err}, 32'd1);
        pulse_reset();

        // Protocol violation: md_busy low during BUSY
        issue(MULT);
        bus.md_busy = 1'b0;
        chk("pv2_err_start", {31'd0, bus.sync_err}, 32'd0);
        @(negedge clk);
        chk("pv2_err_b0", {31'd0, bus.sync_err}, 32'd0);
        @(negedge clk);
        chk("pv2_err_set", {31'd0, bus.sync_err}, 32'd1);
        repeat (4) @(negedge clk);
        chk("pv2_done", {31'd0, bus.md_active}, 32'd0);
        pulse_reset();

        // md_busy high in IDLE without a preceding BUSY
        @(negedge clk);
        bus.md_busy = 1'b1;
        @(negedge clk);
        chk("idle_busy_err", {31'd0, bus.sync_err}, 32'd1);
        pulse_reset();

        // Asynchronous reset mid-BUSY at cycles_left=3
        issue(MULT);
        repeat (3) @(negedge clk);
        chk("ar_cycles_pre", {28'd0, bus.cycles_left}, 32'd3);
        bus.instr_D = MFLO;
        #1;
        chk("ar_stall_pre", {31'd0, bus.stall}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_active", {31'd0, bus.md_active}, 32'd0);
        chk("ar_cycles", {28'd0, bus.cycles_left}, 32'd0);
        chk("ar_stall", {31'd0, bus.stall}, 32'd0);
        bus.md_busy = 1'b0;
        bus.instr_D = NOP;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ar_after_active", {31'd0, bus.md_active}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_hazard_ctrl.md
Name: md_hazard_ctrl

Overview:
- Pipeline hazard controller for the HI/LO multiply/divide unit.
- Watches the D-stage and E-stage instructions and tracks each mult/multu/div/divu from issue to completion with its own shadow counter.
- Stalls D for any HI/LO-touching instruction while an operation is in flight.
- Cross-checks its counter against the unit's busy flag and records any mismatch in a sticky error.

Parameters:
MULT_CYCLES, 5, busy-phase length of mult/multu in cycles (1..15)
DIV_CYCLES, 10, busy-phase length of div/divu in cycles (1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
instr_D  input  32  instruction currently in D stage
instr_E  input  32  instruction currently in E stage
IRQ_E  input  1  interrupt/exception taken at E; suppresses issue of the E instruction
md_busy  input  1  busy flag from the multiply/divide unit
stall  output  1  freeze PC/D, insert bubble into E
md_active  output  1  1 while state is START or BUSY
cycles_left  output  4  remaining BUSY cycles, 0 outside BUSY
is_div  output  1  in-flight op is div/divu (valid while md_active)
sync_err  output  1  sticky protocol/consistency error

Behaviour:
- Decode, applied to both instr_D and instr_E, with opcode [31:26]=000000:
  - MD op: funct 011000, 011001, 011010, 011011.
  - HI/LO use: MD op, or funct 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
- Reset (reset=0, asynchronous): state=IDLE, cycles_left=0, is_div=0, sync_err=0, md_active=0. stall is combinational and is therefore 0 while in reset.
- States: IDLE, START, BUSY.
- IDLE -> START:
  - Condition: rising edge with MD op in E and IRQ_E=0.
  - Latch is_div = funct[1].
- START -> BUSY:
  - Always taken after exactly one cycle.
  - Load cycles_left = DIV_CYCLES if is_div, else MULT_CYCLES.
- BUSY:
  - cycles_left decrements each edge.
  - When cycles_left=1, the next edge goes to IDLE and sets cycles_left=0.
  - Total md_active time is 1 + LAT cycles.
- IRQ_E=1 with an MD op in E: no issue, state unchanged, no error.
- MD op in E while state≠IDLE: ignored (no restart, counter untouched); sync_err set.
- stall = HI/LO use in D AND (state≠IDLE OR (MD op in E AND IRQ_E=0)). Purely combinational, no registered delay.
- A mult in D directly behind a mult in E therefore stalls immediately. Non-HI/LO instructions are never stalled.
- sync_err rules:
  - Checked on each rising edge, using the md_busy value sampled at that edge.
  - Set if state=BUSY and md_busy=0.
  - Set if state=IDLE and md_busy=1 and the previous state was not BUSY (one-cycle release slack allowed after BUSY ends).
  - START is not checked.
  - Cleared only by reset.
- Reset mid-operation: immediate return to IDLE. stall drops in the same cycle reset is asserted.
- Back-to-back operations: the next MD op can issue on the first cycle the controller is in IDLE. The stalled D instruction reaches E one cycle after stall deasserts.

Test Plan:
- Mult issue: mult in E, IRQ_E=0, md_busy driven 1 for 5 cycles after START → md_active high 6 cycles; cycles_left 5,4,3,2,1 then 0; sync_err=0.
- Divide with dependent read: div in E, mflo in D → stall=1 the same cycle and for all 11 cycles of the operation; stall=0 the cycle state returns to IDLE; is_div=1 throughout.
- Interrupt suppression: multu in E with IRQ_E=1 → state stays IDLE, stall=0 for a mfhi in D, sync_err=0.
- Non-HI/LO instruction: addu (funct 100001) in D during BUSY → stall=0; mthi in D during BUSY → stall=1.
- Protocol violation: force a divu into E while BUSY → counter unaffected, sync_err=1 and stays set. Separately, hold md_busy=0 during BUSY → sync_err=1.
- Async reset: assert reset=0 mid-BUSY between clock edges with cycles_left=3 → md_active=0, cycles_left=0, stall=0 immediately, without waiting for a clock edge.
